adder_pipe_param: RTL and testbench

Parametrised, segmented, carry-pipelined adder/subtractor. It succeeds the fixed 64-bit pipelined adder.
- Operands are split into SEG_W-bit segments. One segment is resolved per pipeline stage, with carry rippled stage to stage through registers.
- Adds a subtract mode, a signed-overflow flag and a global stall.
- Sits in the datapath wherever wide accumulations must meet timing at full clock rate.

---
 rtl/adder_pipe_pkg.sv | 28 ++
 rtl/adder_pipe_seg.sv | 54 +++++
 rtl/adder_pipe_param.sv | 111 +++++++++++
 tb/tb_adder_pipe_param.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_pipe_pkg                                                             |
// | Shared geometry helpers and per-segment state for the segmented adder.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package adder_pipe_pkg;

    // Number of pipeline stages. Never returns 0, so a bad geometry still
    // elaborates far enough to hit the geometry check.
    function automatic int calc_nstg(input int width, input int seg_w);
        int n;
        n = (seg_w > 0) ? (width / seg_w) : 1;
        return (n < 1) ? 1 : n;
    endfunction

    function automatic bit geometry_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
    } seg_state_t;

endpackage
`default_nettype wire

// File: rtl/adder_pipe_seg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_pipe_seg                                                             |
// | One SEG_W-bit segment adder with registered sum, carry, valid and ovf.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder_pipe_seg
    import adder_pipe_pkg::*;
#(
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             vin,
    input  logic             cin,
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    output logic [SEG_W-1:0] sum,
    output logic             vout,
    output logic             cout,
    output logic             ovf
);

    logic [SEG_W:0]   w_add;
    seg_state_t       r_state;
    logic [SEG_W-1:0] r_sum;

    assign w_add = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

    // Data only moves on valid beats, so the last stage holds its result
    // across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
            r_sum   <= '0;
        end else if (adv) begin
            r_state.valid <= vin;
            if (vin) begin
                r_state.carry <= w_add[SEG_W];
                r_state.ovf   <= (a[SEG_W-1] == b[SEG_W-1]) &&
                                 (w_add[SEG_W-1] != a[SEG_W-1]);
                r_sum         <= w_add[SEG_W-1:0];
            end
        end
    end

    assign sum  = r_sum;
    assign vout = r_state.valid;
    assign cout = r_state.carry;
    assign ovf  = r_state.ovf;

endmodule
`default_nettype wire

// File: rtl/adder_pipe_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adder_pipe_param                                                           |
// | Segmented carry-pipelined add/sub: one SEG_W segment resolved per stage.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adder_pipe_param
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int SEG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_sub,
    input  logic             i_stall,
    input  logic [WIDTH-1:0] adda,
    input  logic [WIDTH-1:0] addb,
    output logic [WIDTH:0]   result,
    output logic             o_ovf,
    output logic             o_en
);

    localparam int NSTG = calc_nstg(WIDTH, SEG_W);

    if (!geometry_ok(WIDTH, SEG_W)) begin : g_bad_geometry
        $fatal(1, "adder_pipe_param: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)",
               WIDTH, SEG_W);
    end

    // Index s is the input side of stage s; index NSTG is the output side.
    logic             w_adv;
    logic [WIDTH-1:0] w_a_rem    [NSTG];
    logic [WIDTH-1:0] w_b_rem    [NSTG];
    logic [WIDTH-1:0] w_sum_done [NSTG+1];
    logic [NSTG:0]    w_vld;
    logic [NSTG:0]    w_cry;
    logic [NSTG-1:0]  w_ovf;

    assign w_adv         = ~i_stall;
    assign w_a_rem[0]    = adda;
    assign w_b_rem[0]    = i_sub ? ~addb : addb;
    assign w_sum_done[0] = '0;
    assign w_vld[0]      = i_en;
    assign w_cry[0]      = i_sub;

    for (genvar s = 0; s < NSTG; s++) begin : g_stage
        logic [SEG_W-1:0] w_seg_sum;
        logic [WIDTH-1:0] r_done;

        adder_pipe_seg #(
            .SEG_W (SEG_W)
        ) u_seg (
            .clk   (clk),
            .rst_n (rst_n),
            .adv   (w_adv),
            .vin   (w_vld[s]),
            .cin   (w_cry[s]),
            .a     (w_a_rem[s][SEG_W-1:0]),
            .b     (w_b_rem[s][SEG_W-1:0]),
            .sum   (w_seg_sum),
            .vout  (w_vld[s+1]),
            .cout  (w_cry[s+1]),
            .ovf   (w_ovf[s])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_done <= '0;
            end else if (w_adv && w_vld[s]) begin
                r_done <= w_sum_done[s];
            end
        end

        // Resolved segments stay at their final bit position (deskew).
        assign w_sum_done[s+1] = r_done | (WIDTH'(w_seg_sum) << (s * SEG_W));

        if (s < NSTG - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a_rem;
            logic [WIDTH-1:0] r_b_rem;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_rem <= '0;
                    r_b_rem <= '0;
                end else if (w_adv && w_vld[s]) begin
                    r_a_rem <= w_a_rem[s] >> SEG_W;
                    r_b_rem <= w_b_rem[s] >> SEG_W;
                end
            end

            assign w_a_rem[s+1] = r_a_rem;
            assign w_b_rem[s+1] = r_b_rem;
        end
    end

    // Already-shifted-out upper bits and non-final overflow flags are dead.
    if (NSTG > 1) begin : g_unused
        logic w_unused;
        assign w_unused = ^{w_a_rem[NSTG-1][WIDTH-1:SEG_W],
                            w_b_rem[NSTG-1][WIDTH-1:SEG_W],
                            w_ovf[NSTG-2:0]};
    end

    assign result = {w_cry[NSTG], w_sum_done[NSTG]};
    assign o_ovf  = w_ovf[NSTG-1];
    assign o_en   = w_vld[NSTG];

endmodule
`default_nettype wire

// File: tb/tb_adder_pipe_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_adder_pipe_param                                                        |
// | Scoreboard bench over four geometries driven by one directed sequence.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_adder_pipe_param;

    localparam int NCFG  = 4;
    localparam int NVEC  = 13;
    localparam int CW [NCFG] = '{64, 32, 64, 128};
    localparam int CS [NCFG] = '{16, 8, 64, 32};

    typedef struct packed {
        logic [128:0] res;
        logic         ovf;
        int           adv;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         sub;
    logic         stall;
    logic [127:0] a_w;
    logic [127:0] b_w;
    logic [64:0]  exp_res;
    logic         exp_ovf;
    logic         adv_seen = 1'b0;
    int           adv_cnt  = 0;
    int           checks   = 0;
    int           errors   = 0;
    event         ev_rstchk;
    event         ev_idle;
    event         ev_drain;

    // Directed 64-bit vectors with hand-computed {carry, sum} and overflow.
    logic [63:0] va [NVEC] = '{
        64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0005, 64'h8000_0000_0000_0000,
        64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF, 64'h1234_5678_9ABC_DEF0,
        64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0000,
        64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
        64'h0000_0000_0000_0010};
    logic [63:0] vb [NVEC] = '{
        64'h0000_0000_0000_0001, 64'h0000_0000_0000_0007, 64'h0000_0000_0000_0001,
        64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 64'h1234_5678_9ABC_DEF0,
        64'h8000_0000_0000_0000, 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0000,
        64'h1111_1111_1111_1111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001,
        64'h0000_0000_0000_0020};
    logic        vs [NVEC] = '{0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
    logic [64:0] vr [NVEC] = '{
        65'h1_0000_0000_0000_0000, 65'h0_FFFF_FFFF_FFFF_FFFE, 65'h1_7FFF_FFFF_FFFF_FFFF,
        65'h0_8000_0000_0000_0000, 65'h0_0000_0000_0001_0000, 65'h1_0000_0000_0000_0000,
        65'h1_0000_0000_0000_0000, 65'h1_0000_0000_FFFF_FFFF, 65'h1_0000_0000_0000_0000,
        65'h0_1234_5678_9ABC_DF00, 65'h1_0000_0000_0000_0000, 65'h0_0000_0001_0000_0000,
        65'h0_FFFF_FFFF_FFFF_FFF0};
    logic        vo [NVEC] = '{0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        adv_seen <= rst_n && !stall;
        if (rst_n && !stall) adv_cnt <= adv_cnt + 1;
    end

    function automatic logic [127:0] widen(input logic [63:0] x);
        return {x[31:0], x[63:32], x};
    endfunction

    // Plain wide-integer reference: returns {ovf, carry, sum} for width w.
    function automatic logic [129:0] model(input int w, input logic [127:0] a,
                                           input logic [127:0] b, input logic s);
        logic [128:0] mask;
        logic [127:0] am;
        logic [127:0] bp;
        logic [128:0] full;
        logic         ov;
        mask = (129'd1 << w) - 129'd1;
        am   = a & mask[127:0];
        bp   = (s ? ~b : b) & mask[127:0];
        full = {1'b0, am} + {1'b0, bp} + {128'd0, s};
        ov   = (am[w-1] == bp[w-1]) && (full[w-1] != am[w-1]);
        return {ov, full & {mask[127:0], 1'b1}};
    endfunction

    for (genvar i = 0; i < NCFG; i++) begin : g_cfg
        localparam int W = CW[i];
        localparam int S = CS[i];
        localparam int N = W / S;

        logic [W:0] res;
        logic       ovf;
        logic       oen;
        exp_t       q [$];

        adder_pipe_param #(
            .WIDTH (W),
            .SEG_W (S)
        ) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (en),
            .i_sub   (sub),
            .i_stall (stall),
            .adda    (a_w[W-1:0]),
            .addb    (b_w[W-1:0]),
            .result  (res),
            .o_ovf   (ovf),
            .o_en    (oen)
        );

        // Config 0 is scored against the hand table, the others against the model.
        always @(posedge clk) begin
            exp_t         e;
            logic [129:0] m;
            if (rst_n && !stall && en) begin
                m = model(W, a_w, b_w, sub);
                if (i == 0) begin
                    e.res = {64'd0, exp_res};
                    e.ovf = exp_ovf;
                end else begin
                    e.res = m[128:0];
                    e.ovf = m[129];
                end
                e.adv = adv_cnt;
                q.push_back(e);
            end
        end

        always @(negedge rst_n) q.delete();

        always @(negedge clk) begin
            exp_t e;
            if (adv_seen && oen) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL cfg%0d unexpected o_en: got result %h, want no output", i, res);
                end else begin
                    e = q.pop_front();
                    if (res !== e.res[W:0] || ovf !== e.ovf || adv_cnt != e.adv + N) begin
                        errors++;
                        $display("FAIL cfg%0d result: got %h ovf %b adv %0d, want %h ovf %b adv %0d",
                                 i, res, ovf, adv_cnt, e.res[W:0], e.ovf, e.adv + N);
                    end
                end
            end
        end

        always @(ev_rstchk) begin
            checks++;
            if (res !== '0 || ovf !== 1'b0 || oen !== 1'b0) begin
                errors++;
                $display("FAIL cfg%0d reset state: got result %h ovf %b o_en %b, want 0 0 0",
                         i, res, ovf, oen);
            end
        end

        always @(ev_idle) begin
            checks++;
            if (oen !== 1'b0) begin
                errors++;
                $display("FAIL cfg%0d idle o_en: got %b, want 0", i, oen);
            end
        end

        always @(ev_drain) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL cfg%0d drain: got %0d outputs missing, want 0", i, q.size());
            end
        end
    end

    task automatic issue(input int k);
        @(negedge clk);
        a_w     = widen(va[k]);
        b_w     = widen(vb[k]);
        sub     = vs[k];
        en      = 1'b1;
        exp_res = vr[k];
        exp_ovf = vo[k];
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        sub     = 1'b0;
        stall   = 1'b0;
        a_w     = '0;
        b_w     = '0;
        exp_res = '0;
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        -> ev_rstchk;
        @(negedge clk);
        rst_n = 1'b1;

        // Full carry ripple, then the two subtract corner cases.
        issue(0);
        gap(6);
        issue(1);
        issue(2);
        gap(6);

        // Back-to-back stream with one bubble after the third operation.
        for (int k = 3; k <= 5; k++) issue(k);
        gap(1);
        for (int k = 6; k <= 10; k++) issue(k);
        gap(6);

        // Stall three edges with two operations in flight; inputs offered
        // during the stall must be ignored.
        issue(11);
        issue(12);
        @(negedge clk);
        stall = 1'b1;
        en    = 1'b1;
        a_w   = widen(va[0]);
        b_w   = widen(vb[0]);
        repeat (3) @(negedge clk);
        stall = 1'b0;
        en    = 1'b0;
        gap(8);

        // Asynchronous reset mid-cycle with three operations in flight.
        issue(0);
        issue(1);
        issue(2);
        @(negedge clk);
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        -> ev_rstchk;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            -> ev_idle;
        end

        // Recovery after reset.
        issue(9);
        gap(8);

        -> ev_drain;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
